parity_serial_tx: RTL and testbench

//  Serial frame transmitter that sits directly downstream of the combinational parity generator.

---
 rtl/parity_pkg.sv | 16 +
 rtl/bit_timer.sv | 29 ++
 rtl/parity_serial_tx.sv | 110 +++++++++++
 tb/tb_parity_serial_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity serial transmitter: parity mode encodings
// and the frame FSM state type.
package parity_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_end on the last
// cycle of each bit period. clear holds the count at zero between frames.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start(0), data LSB-first, parity, stop(1) x STOP_BITS,
// with the parity bit computed from the word captured at the accepting edge.
module parity_serial_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              mode,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] data_q;
    logic              par_q;
    logic [IDX_W-1:0]  idx;
    logic              stop_cnt;
    logic              bit_end;

    function automatic logic calc_par(input logic [DATA_W-1:0] d, input logic m);
        return (m == PAR_ODD) ? ~(^d) : (^d);
    endfunction

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .bit_end(bit_end)
    );

    // Payload and parity are captured only on acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && valid && !rst) begin
            data_q <= data;
            par_q  <= calc_par(data, mode);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            stop_cnt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx      <= '0;
                    stop_cnt <= 1'b0;
                    if (valid) state <= START;
                end
                START: begin
                    if (bit_end) state <= DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= PARITY;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = data_q[idx];
            PARITY:  tx = par_q;
            default: tx = 1'b1;
        endcase
    end

    assign ready      = (state == IDLE);
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx: cycle-level scoreboard of tx/busy/ready/frame_done
// plus directed parity-slot and reset checks.
module tb_parity_serial_tx;

    localparam int DATA_W       = 4;
    localparam int CLKS_PER_BIT = 4;
    localparam int STOP_BITS    = 1;
    localparam int PAR_SLOT     = 2 + (1 + DATA_W) * CLKS_PER_BIT;

    typedef struct packed {
        logic tx;
        logic done;
    } slot_t;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] data;
    logic              mode;
    logic              valid;
    logic              ready;
    logic              tx;
    logic              busy;
    logic              frame_done;

    int    n_checks;
    int    n_errors;
    int    acc_cnt;
    logic  cur_busy;
    logic  chk_en;
    slot_t exp_q[$];

    parity_serial_tx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .STOP_BITS   (STOP_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .mode      (mode),
        .valid     (valid),
        .ready     (ready),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] d, input logic m);
        int    ones;
        logic  p;
        slot_t s;
        ones = 0;
        for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
        p = (ones % 2 == 0) ? m : !m;
        s.done = 1'b0;
        s.tx   = 1'b0;
        for (int c = 0; c < CLKS_PER_BIT; c++) exp_q.push_back(s);
        for (int i = 0; i < DATA_W; i++) begin
            s.tx = d[i];
            for (int c = 0; c < CLKS_PER_BIT; c++) exp_q.push_back(s);
        end
        s.tx = p;
        for (int c = 0; c < CLKS_PER_BIT; c++) exp_q.push_back(s);
        s.tx = 1'b1;
        for (int c = 0; c < STOP_BITS * CLKS_PER_BIT; c++) begin
            s.done = (c == STOP_BITS * CLKS_PER_BIT - 1);
            exp_q.push_back(s);
        end
    endtask

    // Reference model: accept on the edge when the model is idle, flush on reset.
    initial begin
        acc_cnt = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
            end else if (valid && !cur_busy) begin
                push_frame(data, mode);
                acc_cnt++;
            end
        end
    end

    initial begin
        slot_t s;
        logic  etx, edone;
        cur_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                s        = exp_q.pop_front();
                etx      = s.tx;
                edone    = s.done;
                cur_busy = 1'b1;
            end else begin
                etx      = 1'b1;
                edone    = 1'b0;
                cur_busy = 1'b0;
            end
            if (chk_en) begin
                chk("tx", tx, etx);
                chk("busy", busy, cur_busy);
                chk("ready", ready, !cur_busy);
                chk("frame_done", frame_done, edone);
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input logic m, input logic hold);
        int start_cnt;
        bit got;
        start_cnt = acc_cnt;
        data  = d;
        mode  = m;
        valid = 1'b1;
        got   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acc_cnt != start_cnt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        if (!hold) valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !cur_busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) chk("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_par(input logic [DATA_W-1:0] d, input logic m, input logic exp_par);
        send(d, m, 1'b0);
        repeat (PAR_SLOT - 1) @(negedge clk);
        chk("parity_bit", tx, exp_par);
        wait_idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        valid    = 1'b0;
        data     = '0;
        mode     = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        send_par(4'b1011, 1'b0, 1'b1);
        send_par(4'b1011, 1'b1, 1'b0);
        send_par(4'b0000, 1'b0, 1'b0);
        send_par(4'b0000, 1'b1, 1'b1);
        send_par(4'b1111, 1'b0, 1'b0);

        // Back-to-back with valid held high.
        send(4'h3, 1'b0, 1'b1);
        data = 4'hC;
        send(4'hC, 1'b0, 1'b0);
        wait_idle();

        // A valid pulse mid-frame must be ignored.
        send(4'h6, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        data  = 4'h5;
        valid = 1'b1;
        chk("busy_ready", ready, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        wait_idle();

        // Reset while shifting data bits.
        send(4'h9, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", frame_done, 1'b0);
        send_par(4'b0111, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
